// File: rtl/dr_pfreq_queue_if.sv
// Prefetch-request channel between L2, the prefetch queue and the directory.
// The master drives valid/nid/paddr, and the slave answers with retry.
interface dr_pfreq_if #(
  parameter int NID_W   = 5,
  parameter int PADDR_W = 50
);
  logic               valid;
  logic               retry;
  logic [NID_W-1:0]   nid;
  logic [PADDR_W-1:0] paddr;

  modport master (output valid, output nid, output paddr, input retry);
  modport slave  (input valid, input nid, input paddr, output retry);
endinterface

// File: rtl/dr_pfreq_queue.sv
// Drop-oldest circular prefetch-request queue placed in front of the directory l2todr_pfreq port.
// Optional line-address dedup against queued entries is enabled by defining DR_PFQ_DEDUP_EN.
module dr_pfreq_queue #(
  parameter int DEPTH       = 8,
  parameter int LINE_OFFSET = 6,
  parameter int CNT_W       = 16,
  parameter int NID_W       = 5,
  parameter int PADDR_W     = 50
) (
  input  logic                   clk,
  input  logic                   reset,
  dr_pfreq_if.slave              l2todr_pfreq,
  dr_pfreq_if.master             q_pfreq,
  output logic                   pfq_drop,
  output logic [CNT_W-1:0]       pfq_drop_cnt,
  output logic [$clog2(DEPTH):0] pfq_occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [NID_W-1:0]   nid;
    logic [PADDR_W-1:0] paddr;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic               dup;
  logic               push;
  logic               pop;
  logic               full;

`ifdef DR_PFQ_DEDUP_EN
  // Only the occupied slots, counted from the head, take part in the line compare.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PTR_W+1)'(i) < count_q) begin
        if (mem_q[rd_ptr_q + PTR_W'(i)].paddr[PADDR_W-1:LINE_OFFSET] ==
            l2todr_pfreq.paddr[PADDR_W-1:LINE_OFFSET]) begin
          dup = 1'b1;
        end
      end
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign l2todr_pfreq.retry = 1'b0;
  assign push = l2todr_pfreq.valid && !dup;
  assign pop  = (count_q != '0) && !q_pfreq.retry;
  assign full = (count_q == (PTR_W+1)'(DEPTH));

  assign q_pfreq.valid = (count_q != '0);
  assign q_pfreq.nid   = mem_q[rd_ptr_q].nid;
  assign q_pfreq.paddr = mem_q[rd_ptr_q].paddr;

  assign pfq_drop      = drop_q;
  assign pfq_drop_cnt  = drop_cnt_q;
  assign pfq_occupancy = count_q;

  // A push into a full queue with no pop overwrites the head and advances the head past it.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop || (push && full)) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop && !full) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
    if (push && full && !pop) begin
      drop_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Payload storage is not reset; count gates every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{nid: l2todr_pfreq.nid, paddr: l2todr_pfreq.paddr};
    end
  end

endmodule

// File: tb/tb_dr_pfreq_queue.sv
// Directed bench for dr_pfreq_queue at DEPTH=4 with a 2-bit drop counter so saturation is reachable.
// Define DR_PFQ_DEDUP_EN to also exercise the same-line discard.
module tb_dr_pfreq_queue;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 2;
  localparam int NID_W   = 5;
  localparam int PADDR_W = 50;

  logic                   clk;
  logic                   reset;
  logic                   pfqDrop;
  logic [CNT_W-1:0]       pfqDropCnt;
  logic [$clog2(DEPTH):0] pfqOccupancy;

  int checkCount;
  int passCount;

  dr_pfreq_if #(.NID_W(NID_W), .PADDR_W(PADDR_W)) l2If ();
  dr_pfreq_if #(.NID_W(NID_W), .PADDR_W(PADDR_W)) qIf ();

  dr_pfreq_queue #(
    .DEPTH(DEPTH), .LINE_OFFSET(6), .CNT_W(CNT_W), .NID_W(NID_W), .PADDR_W(PADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .l2todr_pfreq(l2If.slave),
    .q_pfreq(qIf.master),
    .pfq_drop(pfqDrop),
    .pfq_drop_cnt(pfqDropCnt),
    .pfq_occupancy(pfqOccupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [PADDR_W-1:0] paddr, input logic retry);
    l2If.valid = valid;
    l2If.paddr = paddr;
    l2If.nid   = paddr[10:6];
    qIf.retry  = retry;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [PADDR_W-1:0] expHead [4];

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    tick();
    checkOutput("reset_valid", 64'(qIf.valid), 64'd0);
    checkOutput("reset_occ", 64'(pfqOccupancy), 64'd0);
    checkOutput("reset_drop", 64'(pfqDrop), 64'd0);
    checkOutput("reset_dropcnt", 64'(pfqDropCnt), 64'd0);
    checkOutput("l2_retry", 64'(l2If.retry), 64'd0);
    reset = 1'b1;
    tick();

    // Fill under retry
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 50'h1000 + 50'(i * 'h40), 1'b1);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("fill_occ", 64'(pfqOccupancy), 64'd4);
    checkOutput("fill_head", 64'(qIf.paddr), 64'h1000);
    checkOutput("fill_nid", 64'(qIf.nid), 64'h00);
    checkOutput("fill_valid", 64'(qIf.valid), 64'd1);
    checkOutput("fill_nodrop", 64'(pfqDrop), 64'd0);
    tick();
    checkOutput("retry_hold_head", 64'(qIf.paddr), 64'h1000);

    // Overflow drops oldest
    applyStimulus(1'b1, 50'h1100, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("ovf_drop", 64'(pfqDrop), 64'd1);
    checkOutput("ovf_dropcnt", 64'(pfqDropCnt), 64'd1);
    checkOutput("ovf_head", 64'(qIf.paddr), 64'h1040);
    checkOutput("ovf_occ", 64'(pfqOccupancy), 64'd4);
    tick();
    checkOutput("ovf_drop_pulse_end", 64'(pfqDrop), 64'd0);
    qIf.retry = 1'b0;
    expHead = '{50'h1040, 50'h1080, 50'h10C0, 50'h1100};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain1_head%0d", i), 64'(qIf.paddr), 64'(expHead[i]));
      tick();
    end
    checkOutput("drain1_empty", 64'(qIf.valid), 64'd0);
    checkOutput("drain1_occ", 64'(pfqOccupancy), 64'd0);

    // Full queue with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 50'h1000 + 50'(i * 'h40), 1'b1);
      tick();
    end
    applyStimulus(1'b1, 50'h2000, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("pp_occ", 64'(pfqOccupancy), 64'd4);
    checkOutput("pp_nodrop", 64'(pfqDrop), 64'd0);
    checkOutput("pp_dropcnt", 64'(pfqDropCnt), 64'd1);
    qIf.retry = 1'b0;
    expHead = '{50'h1040, 50'h1080, 50'h10C0, 50'h2000};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain2_head%0d", i), 64'(qIf.paddr), 64'(expHead[i]));
      tick();
    end
    checkOutput("drain2_empty", 64'(qIf.valid), 64'd0);

    // Streaming through pointer wrap
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 50'h4000 + 50'(k * 'h40), 1'b0);
      tick();
      checkOutput($sformatf("stream_head%0d", k), 64'(qIf.paddr), 64'h4000 + 64'(k * 'h40));
      checkOutput($sformatf("stream_occ%0d", k), 64'(pfqOccupancy), 64'd1);
    end
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    checkOutput("stream_empty", 64'(qIf.valid), 64'd0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 50'h5000 + 50'(i * 'h40), 1'b1);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("prerst_occ", 64'(pfqOccupancy), 64'd3);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(qIf.valid), 64'd0);
    checkOutput("arst_occ", 64'(pfqOccupancy), 64'd0);
    checkOutput("arst_dropcnt", 64'(pfqDropCnt), 64'd0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 50'h3000, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("postrst_head", 64'(qIf.paddr), 64'h3000);
    checkOutput("postrst_occ", 64'(pfqOccupancy), 64'd1);

    // Drop counter saturation
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b1, 50'h3000 + 50'(i * 'h40), 1'b1);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("sat_dropcnt", 64'(pfqDropCnt), 64'd3);
    checkOutput("sat_head", 64'(qIf.paddr), 64'h3100);
    checkOutput("sat_occ", 64'(pfqOccupancy), 64'd4);

`ifdef DR_PFQ_DEDUP_EN
    qIf.retry = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(1'b1, 50'h1000, 1'b1);
    tick();
    applyStimulus(1'b1, 50'h1020, 1'b1);
    tick();
    checkOutput("dedup_discard_occ", 64'(pfqOccupancy), 64'd1);
    checkOutput("dedup_nodrop", 64'(pfqDrop), 64'd0);
    applyStimulus(1'b1, 50'h1040, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("dedup_enq_occ", 64'(pfqOccupancy), 64'd2);
    checkOutput("dedup_head", 64'(qIf.paddr), 64'h1000);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dr_pfreq_queue.md
Name: dr_pfreq_queue

Overview:
- Prefetch-request buffer directly upstream of the directory bank's l2todr_pfreq port.
- Absorbs L2 prefetch hints (nid + paddr) into a circular buffer and presents them in FIFO order to the directory with valid/retry.
- When the buffer is full it drops the oldest entry. Prefetches carry no ack, so the L2 side is never back-pressured.

Parameters:
- DEPTH, 8, number of entries; legal values 4, 8, 16.
- LINE_OFFSET, 6, low paddr bits ignored for line-address compare (64-byte line).
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- l2todr_pfreq_valid  in  1  prefetch request offered.
- l2todr_pfreq_retry  out  1  constant 0 (never back-pressures).
- l2todr_pfreq_nid  in  $bits(SC_nodeid_type)  requesting node.
- l2todr_pfreq_paddr  in  $bits(SC_paddr_type)  prefetch address.
- q_pfreq_valid  out  1  head entry valid, toward directory.
- q_pfreq_retry  in  1  directory not accepting.
- q_pfreq_nid  out  $bits(SC_nodeid_type)  head nid.
- q_pfreq_paddr  out  $bits(SC_paddr_type)  head paddr.
- pfq_drop  out  1  one-cycle pulse when the oldest entry was overwritten.
- pfq_drop_cnt  out  CNT_W  saturating count of drops.
- pfq_occupancy  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- State:
  - storage array mem[DEPTH] of {nid, paddr};
  - rd_ptr, wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - count, 0..DEPTH;
  - drop pulse register;
  - drop counter.
- Reset (reset=0, asynchronous):
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - q_pfreq_valid = 0, pfq_drop = 0, pfq_drop_cnt = 0, pfq_occupancy = 0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all entries immediately; the first accept after deassertion lands in slot 0.
- Push and pop conditions:
  - push = l2todr_pfreq_valid (retry is never asserted).
  - pop = q_pfreq_valid && !q_pfreq_retry.
- Outputs:
  - q_pfreq_valid = (count != 0).
  - q_pfreq_nid / q_pfreq_paddr = mem[rd_ptr].
  - There is no combinational path from l2todr_pfreq_* to q_pfreq_*.
  - Latency: a request pushed into an empty queue at edge N is visible at the head after edge N; earliest directory accept is at edge N+1.
- Per-cycle cases (all at posedge):
  - No push, no pop: hold.
  - Pop only: rd_ptr++, count--.
  - Push only, not full: mem[wr_ptr] = input, wr_ptr++, count++.
  - Push and pop, any count > 0: write mem[wr_ptr], wr_ptr++, rd_ptr++, count unchanged; no drop.
  - Push only, full (count == DEPTH): wr_ptr == rd_ptr, so overwrite mem[wr_ptr] with the input. Then wr_ptr++ and rd_ptr++, count stays DEPTH. pfq_drop = 1 for the next cycle; pfq_drop_cnt++ saturating at 2^CNT_W-1.
  - Push into empty with retry asserted: normal push; pop cannot occur while empty.
- Head under retry:
  - Payload is stable while q_pfreq_valid && q_pfreq_retry, except on a full-drop cycle.
  - On a full-drop cycle the head advances to the next-oldest entry. This is the sanctioned exception for hint-only traffic; the directory must tolerate it.
- Wrap-around:
  - Pointers wrap DEPTH-1 to 0 with no bubble.
  - count alone distinguishes full from empty.
- pfq_occupancy is the registered count.

Optional Feature:
- Macro: DR_PFQ_DEDUP_EN.
- Defined:
  - Incoming line address paddr[MSB:LINE_OFFSET] is compared with every valid entry (count-qualified, ring order).
  - On a match, the incoming request is silently discarded: no pointer or count change, no drop pulse, no drop_cnt increment.
  - A match against the head being popped in the same cycle still discards.
  - nid is not part of the compare.
- Not defined:
  - No comparators are built; every push is enqueued per the rules above.

Test Plan:
- DEPTH=4, retry=1, push paddr 0x1000, 0x1040, 0x1080, 0x10C0 on consecutive cycles -> occupancy 4, head 0x1000, no drop.
- Continuing that, push 0x1100 with retry=1 -> pfq_drop pulses 1 cycle, drop_cnt=1, head 0x1040, occupancy 4; release retry -> pops in order 0x1040, 0x1080, 0x10C0, 0x1100, then q_pfreq_valid=0.
- Full queue, push 0x2000 with retry=0 the same cycle -> head 0x1000 popped, 0x2000 enqueued, occupancy 4, no drop.
- Stream 10 pushes with retry=0 continuously -> each appears at head one cycle later, outputs in order across pointer wrap, occupancy never exceeds 1.
- Fill 3 entries, assert reset low mid-cycle -> q_pfreq_valid and occupancy 0 immediately; after release, push 0x3000 -> head 0x3000.
- DR_PFQ_DEDUP_EN defined: queue holds 0x1000, push 0x1020 (same line) -> discarded, occupancy unchanged; push 0x1040 -> enqueued.
